alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the CPU's 16-bit combinational ALU.
- Sits between the decode/register-read stage and writeback.
- Registers every result and adds flags (zero, negative, carry, overflow) and a barrel shift by an operand amount.
- Adds an iterative multi-cycle multiply, so the pipeline must stall through valid/ready.

Parameters:
WIDTH, 16, operand and result width in bits (power of two, 8..64)
SHW, $clog2(WIDTH), shift-amount width taken from B[SHW-1:0]

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation presented on A/B/func
in_ready  output  1  block accepts operation this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
func  input  4  function code
out_valid  output  1  result registered and held
out_ready  input  1  consumer takes result this cycle
c  output  WIDTH  result
flag  output  1  condition flag (compare ops)
zf  output  1  c == 0
nf  output  1  c[WIDTH-1]
cf  output  1  carry-out (add) / not-borrow (sub); 0 otherwise
vf  output  1  signed overflow (add/sub/neg); 0 otherwise

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - c, flag, zf, nf, cf, vf, out_valid = 0.
  - FSM = IDLE.
  - Multiply counter and accumulator = 0.
  - in_ready = 1 after reset.
- Reset mid-multiply aborts the operation; no result is emitted.
- Func codes:
  - 0 add, 1 sub, 2 pass A, 3 NOT A, 4 AND, 5 OR.
  - 6 flag=(A!=B), c=A. 7 flag=(A==B), c=A.
  - 8 flag=(A>0 signed), c=A. 9 flag=(A<0 signed), c=A.
  - 10 pass B.
  - 11 MUL: low WIDTH bits of A*B, unsigned.
  - 12 logical shift left by B[SHW-1:0]. 13 arithmetic shift right by B[SHW-1:0] (sign-filled).
  - 14 two's complement. 15 zero.
- flag = 0 for all codes other than 6..9.
- Arithmetic rules:
  - All arithmetic is modulo 2^WIDTH.
  - Add carry is bit WIDTH of A+B, computed at WIDTH+1 bits.
  - Sub cf = (A >= B unsigned).
  - vf is set when operand signs imply overflow. Neg of the most-negative value sets vf=1.
- FSM states: IDLE, MUL, HOLD.
  - IDLE: in_ready=1. Accept on in_valid.
    - Single-cycle op: result and flags registered at the accepting edge; out_valid=1 the next cycle (latency 1). Next state HOLD.
    - func=11: latch A and B, clear accumulator, counter=0, next state MUL.
  - MUL: in_ready=0. One shift-add step per cycle over WIDTH cycles. On the final step, load c and flags, set out_valid, next state HOLD.
    - Latency from accept to out_valid is WIDTH cycles.
  - HOLD: out_valid=1. c and flags stay stable until out_ready.
    - in_ready = out_ready (pass-through), so back-to-back single-cycle ops sustain 1 op/cycle.
    - out_ready & in_valid & single-cycle op: new result loaded, stay HOLD.
    - out_ready & in_valid & MUL: out_valid drops, go MUL.
    - out_ready & !in_valid: out_valid drops, go IDLE.
- Simultaneous events:
  - in_valid with in_ready=0 is ignored. The producer holds the operation.
  - Operand changes while stalled have no effect on a latched MUL.
- zf and nf always describe c, for every func.

Decomposition:
- Shared package alu_pkg:
  - func code localparams (ALU_ADD..ALU_ZERO).
  - FSM state encoding.
  - flag bundle typedef {flag, zf, nf, cf, vf}.
- Sub-module alu_mul_iter: iterative shift-add multiplier with start/done, parametrised by WIDTH.
- The combinational op/flag datapath stays inline.

Test Plan:
1. Reset, then add 0x7FFF + 0x0001 (WIDTH=16) -> one cycle later out_valid=1, c=0x8000, vf=1, nf=1, cf=0, zf=0.
2. Sub 0x0003 - 0x0005 -> c=0xFFFE, cf=0, nf=1. Sub 5-5 -> c=0, zf=1, cf=1.
3. MUL 0x0012 * 0x0034 -> in_ready=0 for 16 cycles, then c=0x03A8. Repeat 0xFFFF*0xFFFF -> c=0x0001.
4. Stream 4 single-cycle ops with out_ready=1 -> 4 results on consecutive cycles. Deassert out_ready for 3 cycles -> c held stable and in_ready=0.
5. SRA 0x8000 by B=4 -> c=0xF800. SHL 0x0001 by B=15 -> c=0x8000. Compare op 7 with A=B=0x1234 -> flag=1, c=0x1234.
6. Assert rst_n=0 at cycle 5 of a MUL -> all outputs 0 immediately. After release, in_ready=1 and no stale result appears. Rerun test 1 at WIDTH=32 with scaled values.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared func codes, FSM states and flag bundle for alu_pipe
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_PASA = 4'd2;
  localparam logic [3:0] ALU_NOTA = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_NE   = 4'd6;
  localparam logic [3:0] ALU_EQ   = 4'd7;
  localparam logic [3:0] ALU_GTZ  = 4'd8;
  localparam logic [3:0] ALU_LTZ  = 4'd9;
  localparam logic [3:0] ALU_PASB = 4'd10;
  localparam logic [3:0] ALU_MUL  = 4'd11;
  localparam logic [3:0] ALU_SHL  = 4'd12;
  localparam logic [3:0] ALU_SRA  = 4'd13;
  localparam logic [3:0] ALU_NEG  = 4'd14;
  localparam logic [3:0] ALU_ZERO = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic flag;
    logic zf;
    logic nf;
    logic cf;
    logic vf;
  } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add multiplier, one partial product per cycle
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand, mplier, acc, acc_next;
  logic [CW-1:0]    cnt;
  logic             busy;

  assign acc_next = acc + (mplier[0] ? mcand : '0);
  // The final step's sum is exposed combinationally so the top loads it on the same edge.
  assign done     = busy && (cnt == CW'(WIDTH - 1));
  assign p        = acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked registered ALU with flags, barrel shifts and iterative multiply
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       func,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             flag,
  output logic             zf,
  output logic             nf,
  output logic             cf,
  output logic             vf
);

  state_t           state_q, state_d;
  logic             accept, is_mul, mul_done;
  logic [WIDTH-1:0] mul_p, alu_c, c_q;
  logic [WIDTH:0]   sum, diff;
  flags_t           alu_fl, fl_q;

  assign is_mul = (func == ALU_MUL);
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = is_mul ? ST_MUL : ST_HOLD;
      ST_MUL:  if (mul_done) state_d = ST_HOLD;
      ST_HOLD: if (out_ready) state_d = !in_valid ? ST_IDLE : (is_mul ? ST_MUL : ST_HOLD);
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    alu_c  = '0;
    alu_fl = '0;
    case (func)
      ALU_ADD: begin
        alu_c     = sum[WIDTH-1:0];
        alu_fl.cf = sum[WIDTH];
        alu_fl.vf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_c     = diff[WIDTH-1:0];
        alu_fl.cf = ~diff[WIDTH];
        alu_fl.vf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_PASA: alu_c = a;
      ALU_NOTA: alu_c = ~a;
      ALU_AND:  alu_c = a & b;
      ALU_OR:   alu_c = a | b;
      ALU_NE:   begin alu_c = a; alu_fl.flag = (a != b); end
      ALU_EQ:   begin alu_c = a; alu_fl.flag = (a == b); end
      ALU_GTZ:  begin alu_c = a; alu_fl.flag = !a[WIDTH-1] && (|a); end
      ALU_LTZ:  begin alu_c = a; alu_fl.flag = a[WIDTH-1]; end
      ALU_PASB: alu_c = b;
      ALU_SHL:  alu_c = a << b[SHW-1:0];
      ALU_SRA:  alu_c = $signed(a) >>> b[SHW-1:0];
      ALU_NEG: begin
        alu_c     = '0 - a;
        alu_fl.vf = (a == {1'b1, {(WIDTH-1){1'b0}}});
      end
      default: alu_c = '0;
    endcase
    alu_fl.zf = (alu_c == '0);
    alu_fl.nf = alu_c[WIDTH-1];
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && is_mul),
    .a     (a),
    .b     (b),
    .done  (mul_done),
    .p     (mul_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q  <= '0;
      fl_q <= '0;
    end else if (accept && !is_mul) begin
      c_q  <= alu_c;
      fl_q <= alu_fl;
    end else if (mul_done) begin
      c_q  <= mul_p;
      fl_q <= {1'b0, ~|mul_p, mul_p[WIDTH-1], 2'b00};
    end
  end

  assign c    = c_q;
  assign flag = fl_q.flag;
  assign zf   = fl_q.zf;
  assign nf   = fl_q.nf;
  assign cf   = fl_q.cf;
  assign vf   = fl_q.vf;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench for alu_pipe at WIDTH=16 plus an add check at WIDTH=32
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [15:0] a = '0, b = '0, c;
  logic [3:0]  func = '0;
  logic        flag, zf, nf, cf, vf;

  logic        in_valid32 = 1'b0, in_ready32, out_valid32, out_ready32 = 1'b1;
  logic [31:0] a32 = '0, b32 = '0, c32;
  logic [3:0]  func32 = '0;
  logic        flag32, zf32, nf32, cf32, vf32;

  typedef struct {
    logic [15:0] c;
    logic [4:0]  fl;
  } exp_t;

  exp_t sbq[$];
  int   xfer_cyc[$];
  int   total = 0, bad = 0, nxfer = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .func(func), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .flag(flag), .zf(zf), .nf(nf), .cf(cf), .vf(vf)
  );

  alu_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .func(func32), .out_valid(out_valid32), .out_ready(out_ready32),
    .c(c32), .flag(flag32), .zf(zf32), .nf(nf32), .cf(cf32), .vf(vf32)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic [3:0] f);
    exp_t e;
    int sx, sy, wide;
    logic signed [15:0] xs;
    logic [31:0] prod;
    logic fg, cy, ov;
    sx = int'($signed(x));
    sy = int'($signed(y));
    xs = x;
    fg = 0; cy = 0; ov = 0;
    case (f)
      0:  begin e.c = x + y; cy = (int'(x) + int'(y)) > 65535; wide = sx + sy; ov = wide > 32767 || wide < -32768; end
      1:  begin e.c = x - y; cy = x >= y; wide = sx - sy; ov = wide > 32767 || wide < -32768; end
      2:  e.c = x;
      3:  e.c = ~x;
      4:  e.c = x & y;
      5:  e.c = x | y;
      6:  begin e.c = x; fg = x != y; end
      7:  begin e.c = x; fg = x == y; end
      8:  begin e.c = x; fg = sx > 0; end
      9:  begin e.c = x; fg = sx < 0; end
      10: e.c = y;
      11: begin prod = {16'h0, x} * {16'h0, y}; e.c = prod[15:0]; end
      12: e.c = x << y[3:0];
      13: e.c = xs >>> y[3:0];
      14: begin e.c = 16'h0 - x; wide = -sx; ov = wide > 32767; end
      default: e.c = 16'h0;
    endcase
    e.fl = {fg, e.c == 16'h0, e.c[15], cy, ov};
    return e;
  endfunction

  // Result transfers happen at the posedge after a negedge with out_valid & out_ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_result observed=%0h expected=none", c);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("res_c", c, e.c);
        chk("res_flags", {flag, zf, nf, cf, vf}, e.fl);
      end
      nxfer++;
      xfer_cyc.push_back(cyc);
    end
  end

  task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic [3:0] f);
    in_valid = 1'b1;
    a = x; b = y; func = f;
    sbq.push_back(model(x, y, f));
  endtask

  task automatic wait_acc(output int w);
    w = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 100) begin
        chk("accept_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [3:0] f, output int w);
    drive(x, y, f);
    wait_acc(w);
  endtask

  initial begin
    int w, n0, t0;

    #2;
    chk("rst_c", c, 0);
    chk("rst_flags", {flag, zf, nf, cf, vf}, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Add overflow: result visible right after the accepting edge.
    send(16'h7FFF, 16'h0001, 4'd0, w);
    chk("add_latency", out_valid, 1);
    chk("add_c_now", c, 16'h8000);
    send(16'h0003, 16'h0005, 4'd1, w);
    send(16'h0005, 16'h0005, 4'd1, w);
    @(posedge clk); #1;

    // Multiply stalls the input side for WIDTH cycles.
    send(16'h0012, 16'h0034, 4'd11, w);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("mul_stall_in_ready", in_ready, 0);
    end
    @(negedge clk);
    chk("mul_out_valid", out_valid, 1);
    chk("mul_c", c, 16'h03A8);
    @(posedge clk); #1;
    send(16'hFFFF, 16'hFFFF, 4'd11, w);
    repeat (20) @(posedge clk);
    #1;

    // Back-to-back stream sustains one op per cycle.
    n0 = nxfer;
    t0 = 0;
    send(16'h00F0, 16'h0F0F, 4'd4, w); t0 += w;
    send(16'h00F0, 16'h0F0F, 4'd5, w); t0 += w;
    send(16'h1234, 16'h0000, 4'd3, w); t0 += w;
    send(16'h0000, 16'hBEEF, 4'd10, w); t0 += w;
    chk("stream_no_wait", t0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("stream_count", nxfer - n0, 4);
    if (xfer_cyc.size() >= 4)
      chk("stream_consecutive", xfer_cyc[xfer_cyc.size()-1] - xfer_cyc[xfer_cyc.size()-4], 3);

    // Consumer stall: result held, input side back-pressured.
    send(16'h8000, 16'h0001, 4'd14, w);
    out_ready = 1'b0;
    drive(16'h4000, 16'h0000, 4'd8);
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_c", c, 16'h8000);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_acc(w);

    send(16'h8000, 16'h0004, 4'd13, w);
    chk("sra_c_now", c, 16'hF800);
    send(16'h0001, 16'h000F, 4'd12, w);
    send(16'h1234, 16'h1234, 4'd7, w);
    send(16'h1234, 16'h1234, 4'd6, w);
    send(16'hFFFF, 16'h0000, 4'd9, w);
    send(16'hAAAA, 16'h5555, 4'd15, w);
    send(16'h8000, 16'h8000, 4'd0, w);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", sbq.size(), 0);

    // Reset in the middle of a multiply: nothing may come out afterwards.
    send(16'h0101, 16'h0202, 4'd11, w);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_c", c, 0);
    chk("midrst_flags", {flag, zf, nf, cf, vf}, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    sbq.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    n0 = nxfer;
    repeat (25) @(posedge clk);
    #1;
    chk("postrst_no_result", nxfer - n0, 0);
    chk("postrst_out_valid", out_valid, 0);
    chk("postrst_in_ready", in_ready, 1);
    send(16'h0002, 16'h0003, 4'd0, w);
    @(posedge clk); #1;

    // Same add-overflow case at WIDTH=32.
    chk("w32_in_ready", in_ready32, 1);
    in_valid32 = 1'b1; a32 = 32'h7FFF_FFFF; b32 = 32'h0000_0001; func32 = 4'd0;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    chk("w32_out_valid", out_valid32, 1);
    chk("w32_c", c32, 32'h8000_0000);
    chk("w32_flags", {flag32, zf32, nf32, cf32, vf32}, 5'b00101);

    repeat (2) @(posedge clk);
    #1;
    chk("final_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
